// File: rtl/dds_freq_detector.sv
// Recovers the DDS frequency word from a signed sine stream: hysteretic rising
// zero-crossing detector, 2^AVG_LOG2-period averaging and a serial restoring divider.
module dds_freq_detector #(
  parameter int PHASE_WIDTH = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int HYST        = 1024,
  parameter int AVG_LOG2    = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst_active_high,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  input  logic                         sample_valid,
  output logic [PHASE_WIDTH-1:0]       freq_word_out,
  output logic                         freq_valid,
  output logic                         locked,
  output logic                         div_busy
);
  localparam int SUM_W  = CNT_WIDTH + AVG_LOG2;
  localparam int NUM_W  = PHASE_WIDTH + AVG_LOG2 + 1;
  localparam int REM_W  = (SUM_W + 1 > NUM_W) ? SUM_W + 1 : NUM_W;
  localparam int IDX_W  = AVG_LOG2 + 1;
  localparam int STEP_W = $clog2(PHASE_WIDTH + 3);

  localparam logic signed [DATA_WIDTH-1:0] NEG_HYST = DATA_WIDTH'(-HYST);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);
  localparam logic [NUM_W-1:0]     NUM      = NUM_W'(1) << (PHASE_WIDTH + AVG_LOG2);
  // Bits of N above the quotient window seed the remainder; the rest shift in.
  localparam logic [REM_W-1:0]     REM_INIT = REM_W'(NUM >> (PHASE_WIDTH + 1));
  localparam logic [PHASE_WIDTH:0] NUM_LO   = NUM[PHASE_WIDTH:0];

  typedef enum logic [1:0] {IDLE, ARMED, RUN_LOW, RUN_ARMED} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] count, cnt_inc;
  logic [IDX_W-1:0]     idx;
  logic [SUM_W-1:0]     period_sum, sum_next;
  logic                 below, nonneg, running, crossing, sum_done, timeout, start;

  assign below    = sample_in < NEG_HYST;
  assign nonneg   = !sample_in[DATA_WIDTH-1];
  assign running  = (state == RUN_LOW) || (state == RUN_ARMED);
  assign crossing = sample_valid && (state == RUN_ARMED) && nonneg;
  assign cnt_inc  = count + 1'b1;
  assign sum_next = period_sum + SUM_W'(cnt_inc);
  assign sum_done = crossing && (idx == IDX_LAST);
  assign timeout  = sample_valid && running && !crossing && (cnt_inc == CNT_MAX);
  // A sum completing while the divider is busy is dropped (overrun).
  assign start    = sum_done && !div_busy;

  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      state      <= IDLE;
      count      <= '0;
      idx        <= '0;
      period_sum <= '0;
    end else if (sample_valid) begin
      case (state)
        IDLE: if (below) state <= ARMED;
        ARMED: if (nonneg) begin
          state      <= RUN_LOW;
          count      <= '0;
          idx        <= '0;
          period_sum <= '0;
        end
        default: begin
          if (timeout) begin
            state      <= IDLE;
            count      <= '0;
            idx        <= '0;
            period_sum <= '0;
          end else if (crossing) begin
            state <= RUN_LOW;
            count <= '0;
            if (sum_done) begin
              idx        <= '0;
              period_sum <= '0;
            end else begin
              idx        <= idx + 1'b1;
              period_sum <= sum_next;
            end
          end else begin
            count <= cnt_inc;
            if (state == RUN_LOW && below) state <= RUN_ARMED;
          end
        end
      endcase
    end
  end

  logic [SUM_W-1:0]     den;
  logic [REM_W-1:0]     rem, rem_sh;
  logic [PHASE_WIDTH:0] quo, nsh;
  logic [STEP_W-1:0]    step;
  logic                 ovf, rem_ge;

  assign rem_sh = {rem[REM_W-2:0], nsh[PHASE_WIDTH]};
  assign rem_ge = rem_sh >= REM_W'(den);

  // Steps 0..PHASE_WIDTH produce quotient bits; the result lands at step PHASE_WIDTH+2.
  always_ff @(posedge clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      freq_word_out <= '0;
      freq_valid    <= 1'b0;
      locked        <= 1'b0;
      div_busy      <= 1'b0;
      den           <= '0;
      rem           <= '0;
      quo           <= '0;
      nsh           <= '0;
      step          <= '0;
      ovf           <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      if (timeout) begin
        div_busy      <= 1'b0;
        locked        <= 1'b0;
        freq_word_out <= '0;
      end else if (start) begin
        div_busy <= 1'b1;
        den      <= sum_next;
        rem      <= REM_INIT;
        nsh      <= NUM_LO;
        quo      <= '0;
        step     <= '0;
        ovf      <= REM_INIT >= REM_W'(sum_next);
      end else if (div_busy) begin
        step <= step + 1'b1;
        if (step <= STEP_W'(PHASE_WIDTH)) begin
          rem <= rem_ge ? rem_sh - REM_W'(den) : rem_sh;
          quo <= {quo[PHASE_WIDTH-1:0], rem_ge};
          nsh <= {nsh[PHASE_WIDTH-1:0], 1'b0};
        end
        if (step == STEP_W'(PHASE_WIDTH + 2)) begin
          div_busy      <= 1'b0;
          freq_valid    <= 1'b1;
          locked        <= 1'b1;
          freq_word_out <= (ovf || quo[PHASE_WIDTH]) ? '1 : quo[PHASE_WIDTH-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_dds_freq_detector.sv
// Directed bench for dds_freq_detector: DDS and synthetic waveforms, latency,
// hysteresis, timeout (8-bit counter instance) and reset mid-division.
module tb_dds_freq_detector;
  logic clk = 1'b0;
  logic rst_active_high;
  logic signed [15:0] sample_in;
  logic sample_valid;
  logic [9:0] fw, fw8;
  logic fv, fv8, lk, lk8, bz, bz8;

  always #5 clk = ~clk;

  dds_freq_detector dut (
    .clk(clk), .rst_active_high(rst_active_high), .sample_in(sample_in),
    .sample_valid(sample_valid), .freq_word_out(fw), .freq_valid(fv),
    .locked(lk), .div_busy(bz));

  dds_freq_detector #(.CNT_WIDTH(8)) dut8 (
    .clk(clk), .rst_active_high(rst_active_high), .sample_in(sample_in),
    .sample_valid(sample_valid), .freq_word_out(fw8), .freq_valid(fv8),
    .locked(lk8), .div_busy(bz8));

  int checks = 0, failures = 0, ts = 0;
  int exp_word = 0, exp_gap = 0;
  bit mon_en = 1'b0;
  int fv_n, fv_first, fv_last, fv8_n, fv8_last;
  int ph;

  typedef struct {
    int kind; int fw; bit tog; int exp_word; int exp_gap; int exp_first; int exp_n; int n_samp;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at t=%0d: got %0d expected %0d", nm, ts, act, req);
    end
  endtask

  function automatic int dds(input int p);
    return $rtoi(32000.0 * $sin(6.283185307179586 * p / 1024.0));
  endfunction

  // kind 1: square +-2000; kind 2: square with 0 crossing and sub-threshold noise;
  // kind 3: negative half sits exactly at -HYST (never arms)
  function automatic int pat(input int kind, input int t);
    int k;
    k = t % 8;
    if (kind == 3) return (k < 4) ? -1024 : 2000;
    if (k < 4) return -2000;
    if (kind == 1) return 2000;
    case (k)
      4: return 0;
      5: return -1024;
      6: return 0;
      default: return -500;
    endcase
  endfunction

  task automatic clear_mon();
    ts = 0; fv_n = 0; fv_first = -1; fv_last = -1; fv8_n = 0; fv8_last = -1;
  endtask

  task automatic tick(input int s, input bit v);
    sample_in = 16'(s);
    sample_valid = v;
    @(posedge clk); #1;
    if (fv) begin
      if (mon_en) begin
        chk("word", int'(fw), exp_word);
        if (fv_n > 0) chk("gap", ts - fv_last, exp_gap);
      end
      if (fv_n == 0) fv_first = ts;
      fv_n++;
      fv_last = ts;
    end
    if (fv8) begin
      fv8_n++;
      fv8_last = ts;
    end
    ts++;
  endtask

  task automatic do_reset();
    rst_active_high = 1'b1; sample_in = '0; sample_valid = 1'b0;
    @(posedge clk); #1;
    rst_active_high = 1'b0;
    clear_mon();
  endtask

  task automatic run_vec(input vec_t v);
    int p = 0;
    bit vl;
    do_reset();
    exp_word = v.exp_word; exp_gap = v.exp_gap; mon_en = 1'b1;
    for (int t = 0; t < v.n_samp; t++) begin
      vl = !v.tog || (t % 2 == 0);
      if (v.kind == 0) begin
        tick(dds(p), vl);
        if (vl) p = (p + v.fw) % 1024;
      end else tick(pat(v.kind, t), vl);
    end
    chk("pulses", fv_n, v.exp_n);
    chk("first_valid_t", fv_first, v.exp_first);
    chk("locked", int'(lk), 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_active_high = 1'b1; sample_in = '0; sample_valid = 1'b0;
    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_word", int'(fw), 0);   chk("rst_valid", int'(fv), 0);
    chk("rst_locked", int'(lk), 0); chk("rst_busy", int'(bz), 0);
    chk("rst_word8", int'(fw8), 0); chk("rst_valid8", int'(fv8), 0);
    chk("rst_locked8", int'(lk8), 0); chk("rst_busy8", int'(bz8), 0);

    //        kind fw tog word gap  first n  samples
    vt[0] = '{0, 8, 1'b0, 8,   512,  653,  7, 4096};
    vt[1] = '{0, 3, 1'b0, 3,   1365, 1720, 2, 3100};
    vt[2] = '{1, 0, 1'b0, 128, 32,   49,   3, 120};
    vt[3] = '{0, 8, 1'b1, 8,   1024, 1293, 5, 6000};
    vt[4] = '{2, 0, 1'b0, 128, 32,   49,   3, 120};
    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    // -HYST exactly must not arm
    do_reset(); mon_en = 1'b0;
    for (int t = 0; t < 200; t++) tick(pat(3, t), 1'b1);
    chk("no_arm_pulses", fv_n, 0);
    chk("no_arm_locked", int'(lk), 0);

    // divider busy window, then reset while a division is in flight
    do_reset(); mon_en = 1'b1; exp_word = 128; exp_gap = 32;
    for (int t = 0; t < 106; t++) begin
      tick(pat(1, t), 1'b1);
      if (t == 35) chk("busy_pre", int'(bz), 0);
      if (t == 37) chk("busy_run", int'(bz), 1);
      if (t == 48) chk("busy_last", int'(bz), 1);
      if (t == 49) chk("busy_done", int'(bz), 0);
    end
    chk("busy_before_rst", int'(bz), 1);
    rst_active_high = 1'b1;
    #1;
    chk("midrst_word", int'(fw), 0);   chk("midrst_locked", int'(lk), 0);
    chk("midrst_busy", int'(bz), 0);   chk("midrst_valid", int'(fv), 0);
    @(posedge clk); #1;
    rst_active_high = 1'b0;
    clear_mon();
    for (int t = 0; t < 120; t++) tick(pat(1, t), 1'b1);
    chk("post_rst_pulses", fv_n, 3);
    chk("post_rst_first", fv_first, 49);

    // timeout on the 8-bit-counter instance: stuck at +500 after lock
    do_reset(); mon_en = 1'b0; ph = 0;
    for (int t = 0; t < 1200; t++) begin
      tick(dds(ph), 1'b1);
      ph = (ph + 8) % 1024;
    end
    chk("to_word8_locked", int'(fw8), 8);
    chk("to_lock8_before", int'(lk8), 1);
    for (int t = 1200; t < 1408; t++) begin
      tick(500, 1'b1);
      if (t == 1406) chk("to_lock8_pre", int'(lk8), 1);
      if (t == 1407) begin
        chk("to_lock8", int'(lk8), 0);
        chk("to_word8", int'(fw8), 0);
        chk("to_lock16_held", int'(lk), 1);
      end
    end
    fv8_n = 0; ph = 0;
    for (int t = 1408; t < 2108; t++) begin
      tick(dds(ph), 1'b1);
      ph = (ph + 8) % 1024;
    end
    chk("relock8_pulses", fv8_n, 1);
    chk("relock8_t", fv8_last, 2061);
    chk("relock8_word", int'(fw8), 8);
    chk("relock8_locked", int'(lk8), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
